// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame controller for the render pipeline (gpu_clk domain).
// Runs the frame timer and pulses framebuffer switch/clear. Triggers matrix_gen,
// holds vertex_fetch in reset until the framebuffer is ready again, and counts
// pixels and frames.
// Optional statistics: define FRAME_SEQ_STATS_EN to enable last_pixel_count_out
// and missed_frame_count_out. Without it, both ports are tied to zero.
module frame_sequencer #(
   parameter int FRAME_PERIOD  = 2_000_000,
   parameter int SETTLE_CYCLES = 100,
   parameter int TIMER_WIDTH   = 22,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   framebuffer_ready_in,
   input  logic                   pixel_valid_in,
   output logic                   switch_out,
   output logic                   clear_out,
   output logic                   matrix_start_out,
   output logic                   fetch_rst_out,
   output logic                   frame_done_out,
   output logic [COUNT_WIDTH-1:0] pixel_count_out,
   output logic [COUNT_WIDTH-1:0] frame_count_out,
   output logic [COUNT_WIDTH-1:0] last_pixel_count_out,
   output logic [COUNT_WIDTH-1:0] missed_frame_count_out
);

   typedef enum logic [1:0] {
      RENDER   = 2'd0,
      WAIT_BUF = 2'd1,
      LAUNCH   = 2'd2
   } state_t;

   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST   = TIMER_WIDTH'(FRAME_PERIOD - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_SETTLE = TIMER_WIDTH'(SETTLE_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;

   state_t                   state;
   state_t                   state_next;
   logic [TIMER_WIDTH-1:0]   timer;
   logic                     matrix_next;
   logic                     fetch_next;
   logic                     done_next;
   logic [COUNT_WIDTH-1:0]   pixel_next;
   logic [COUNT_WIDTH-1:0]   frame_next;
   logic [COUNT_WIDTH-1:0]   pixel_sat;

   // Saturating pixel increment. It is shared by RENDER and WAIT_BUF, because
   // the pipeline still drains pixels while the sequencer waits for the buffer.
   assign pixel_sat = (pixel_valid_in && (pixel_count_out != COUNT_MAX))
                      ? pixel_count_out + 1'b1 : pixel_count_out;

   // Free-running frame timer with the switch/clear pulses; independent of the FSM.
   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of block ordering.
      if (!rst_in) begin
         timer      <= '0;
         switch_out <= 1'b0;
         clear_out  <= 1'b1;
      end else if (timer == TIMER_LAST) begin
         timer      <= '0;
         switch_out <= 1'b1;
         clear_out  <= 1'b1;
      end else begin
         timer      <= timer + 1'b1;
         switch_out <= 1'b0;
         clear_out  <= 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) state <= RENDER;
      else         state <= state_next;
   end

   // Next-state and next-output logic; the outputs are registered below.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can leave
      // one unassigned and infer a latch.
      state_next  = state;
      matrix_next = 1'b0;
      fetch_next  = fetch_rst_out;
      done_next   = 1'b0;
      pixel_next  = pixel_count_out;
      frame_next  = frame_count_out;
      case (state)
         RENDER: begin
            pixel_next = pixel_sat;
            if (!framebuffer_ready_in && (timer >= TIMER_SETTLE)) begin
               matrix_next = 1'b1;
               fetch_next  = 1'b1;
               state_next  = WAIT_BUF;
            end
         end
         WAIT_BUF: begin
            pixel_next = pixel_sat;
            if (framebuffer_ready_in) begin
               fetch_next = 1'b0;
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            pixel_next = {{(COUNT_WIDTH-1){1'b0}}, pixel_valid_in};
            frame_next = frame_count_out + 1'b1;
            done_next  = 1'b1;
            state_next = RENDER;
         end
         default: state_next = RENDER;
      endcase
   end

   // Registered FSM outputs and counters.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         matrix_start_out <= 1'b0;
         fetch_rst_out    <= 1'b1;
         frame_done_out   <= 1'b0;
         pixel_count_out  <= '0;
         frame_count_out  <= '0;
      end else begin
         matrix_start_out <= matrix_next;
         fetch_rst_out    <= fetch_next;
         frame_done_out   <= done_next;
         pixel_count_out  <= pixel_next;
         frame_count_out  <= frame_next;
      end
   end

`ifdef FRAME_SEQ_STATS_EN
   logic [COUNT_WIDTH-1:0] last_pixel_count;
   logic [COUNT_WIDTH-1:0] missed_count;

   // Statistics: capture the finished frame's pixel total and count any switch
   // pulses that fire while the buffer is still not ready.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         last_pixel_count <= '0;
         missed_count     <= '0;
      end else begin
         if (state == LAUNCH) last_pixel_count <= pixel_count_out;
         if (switch_out && (state == WAIT_BUF)) missed_count <= missed_count + 1'b1;
      end
   end

   assign last_pixel_count_out   = last_pixel_count;
   assign missed_frame_count_out = missed_count;
`else
   assign last_pixel_count_out   = '0;
   assign missed_frame_count_out = '0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: table-driven vectors and directed sequences for frame_sequencer.
// A behavioural model pushes expected outputs to a scoreboard queue on every
// driven cycle. The queue is popped and compared after each clock edge.
// A second instance with a 4-bit counter width covers frame-count wrap and pixel saturation.
module tb_frame_sequencer;

   localparam int FP = 20;
   localparam int SC = 4;
   localparam int CW = 16;
   localparam int NW = 4;
`ifdef FRAME_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam int S_RENDER = 0;
   localparam int S_WAIT   = 1;
   localparam int S_LAUNCH = 2;

   logic clk;
   logic rst;
   logic fb_ready;
   logic pix_valid;

   logic          sw, clr, mat, fet, done;
   logic [CW-1:0] pix, frm, last, miss;
   logic          sw_w, clr_w, mat_w, fet_w, done_w;
   logic [NW-1:0] pix_w, frm_w, last_w, miss_w;

   frame_sequencer #(
      .FRAME_PERIOD(FP), .SETTLE_CYCLES(SC), .TIMER_WIDTH(22), .COUNT_WIDTH(CW)
   ) dut (
      .clk_in(clk), .rst_in(rst), .framebuffer_ready_in(fb_ready), .pixel_valid_in(pix_valid),
      .switch_out(sw), .clear_out(clr), .matrix_start_out(mat), .fetch_rst_out(fet),
      .frame_done_out(done), .pixel_count_out(pix), .frame_count_out(frm),
      .last_pixel_count_out(last), .missed_frame_count_out(miss)
   );

   frame_sequencer #(
      .FRAME_PERIOD(FP), .SETTLE_CYCLES(SC), .TIMER_WIDTH(22), .COUNT_WIDTH(NW)
   ) dut_w (
      .clk_in(clk), .rst_in(rst), .framebuffer_ready_in(fb_ready), .pixel_valid_in(pix_valid),
      .switch_out(sw_w), .clear_out(clr_w), .matrix_start_out(mat_w), .fetch_rst_out(fet_w),
      .frame_done_out(done_w), .pixel_count_out(pix_w), .frame_count_out(frm_w),
      .last_pixel_count_out(last_w), .missed_frame_count_out(miss_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic          sw, clr, mat, fet, done;
      logic [CW-1:0] pix, frm, last, miss;
   } outs_t;

   outs_t sb_q[$];

   // Reference model state.
   int          m_timer;
   int          m_state;
   logic        m_sw, m_clr, m_mat, m_fet, m_done;
   logic [15:0] m_pix, m_frm, m_last, m_miss;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge.
   task automatic model_edge(input logic r, input logic rd, input logic v);
      if (!r) begin
         m_timer = 0; m_state = S_RENDER;
         m_sw = 1'b0; m_clr = 1'b1; m_mat = 1'b0; m_fet = 1'b1; m_done = 1'b0;
         m_pix = '0; m_frm = '0; m_last = '0; m_miss = '0;
      end else begin
         if (m_sw && m_state == S_WAIT) m_miss++;
         m_mat  = 1'b0;
         m_done = 1'b0;
         case (m_state)
            S_RENDER: begin
               if (v && m_pix != 16'hFFFF) m_pix++;
               if (!rd && m_timer >= SC) begin
                  m_mat = 1'b1; m_fet = 1'b1; m_state = S_WAIT;
               end
            end
            S_WAIT: begin
               if (v && m_pix != 16'hFFFF) m_pix++;
               if (rd) begin
                  m_fet = 1'b0; m_state = S_LAUNCH;
               end
            end
            default: begin
               m_last  = m_pix;
               m_pix   = v ? 16'd1 : 16'd0;
               m_frm++;
               m_done  = 1'b1;
               m_state = S_RENDER;
            end
         endcase
         if (m_timer == FP - 1) begin
            m_timer = 0; m_sw = 1'b1; m_clr = 1'b1;
         end else begin
            m_timer++; m_sw = 1'b0; m_clr = 1'b0;
         end
      end
   endtask

   function automatic outs_t model_outs();
      outs_t o;
      o.sw = m_sw; o.clr = m_clr; o.mat = m_mat; o.fet = m_fet; o.done = m_done;
      o.pix = m_pix; o.frm = m_frm;
      o.last = STATS ? m_last : 16'd0;
      o.miss = STATS ? m_miss : 16'd0;
      return o;
   endfunction

   function automatic outs_t dut_outs();
      outs_t o;
      o.sw = sw; o.clr = clr; o.mat = mat; o.fet = fet; o.done = done;
      o.pix = pix; o.frm = frm; o.last = last; o.miss = miss;
      return o;
   endfunction

   // Drive one cycle, score it against the model, and sample 1 time unit after the edge.
   task automatic step(input logic r, input logic rd, input logic v);
      outs_t e;
      outs_t a;
      rst       = r;
      fb_ready  = rd;
      pix_valid = v;
      model_edge(r, rd, v);
      sb_q.push_back(model_outs());
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      a = dut_outs();
      check("scoreboard", a, e);
   endtask

   typedef struct {
      logic          r, rd, v;
      int            cycles;
      logic          sw, clr, mat, fet, done;
      logic [CW-1:0] frm;
   } vec_t;

   vec_t tbl[13];
   int   sw_seen;
   int   waited;
   bit   seen;
   bit   timed_out;

   initial begin
      rst = 1'b0; fb_ready = 1'b1; pix_valid = 1'b0;

      // Reset, first frame launch, and switch/clear period. Values are read at the end of each segment.
      //           r     rd    v     n   sw    clr   mat   fet   done  frm
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};

      for (int i = 0; i < 13; i++) begin
         repeat (tbl[i].cycles) step(tbl[i].r, tbl[i].rd, tbl[i].v);
         check($sformatf("tbl[%0d]", i), {sw, clr, mat, fet, done, frm},
               {tbl[i].sw, tbl[i].clr, tbl[i].mat, tbl[i].fet, tbl[i].done, tbl[i].frm});
      end

      // Pixels: 7 in RENDER, 2 in WAIT_BUF, 1 on the LAUNCH cycle.
      repeat (7) step(1'b1, 1'b1, 1'b1);
      check("pixels in render", pix, 16'd7);
      step(1'b1, 1'b0, 1'b0);
      check("matrix_start on not-ready", mat, 1'b1);
      repeat (2) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      check("pixels before launch", pix, 16'd9);
      step(1'b1, 1'b1, 1'b1);
      check("pixel restart at launch", pix, 16'd1);
      check("frame_count second frame", frm, 16'd2);
      check("frame_done second frame", done, 1'b1);
      check("last_pixel_count", last, STATS ? 16'd9 : 16'd0);

      // 45 cycles stuck in WAIT_BUF cover two switch pulses.
      step(1'b1, 1'b0, 1'b0);
      sw_seen = 0;
      for (int k = 0; k < 45; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (sw) sw_seen++;
      end
      check("switch pulses while waiting", sw_seen, 2);
      check("missed_frame_count", miss, STATS ? 16'd2 : 16'd0);
      repeat (2) step(1'b1, 1'b1, 1'b0);
      check("missed count after launch", miss, STATS ? 16'd2 : 16'd0);
      check("frame_count third frame", frm, 16'd3);

      // Reset asserted while in WAIT_BUF.
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b0);
         check("no exit before settle", mat, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0);
      check("exit at settle", mat, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("reset mid-wait", {sw, clr, mat, fet, done, pix, frm},
            {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0});
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b0);
         check("timer restarted after reset", mat, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0);
      check("render state after reset", mat, 1'b1);

      // Narrow counters: pixel saturation and frame-count wrap.
      step(1'b0, 1'b1, 1'b0);
      check("narrow reset", {sw_w, clr_w, mat_w, fet_w, done_w, pix_w, frm_w, last_w, miss_w},
            {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0});
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b1, 1'b1);
         if (k == 15) check("narrow pixel reaches max", pix_w, 4'hF);
      end
      check("narrow pixel saturated", pix_w, 4'hF);
      check("wide pixel count", pix, 16'd20);

      timed_out = 1'b0;
      for (int f = 1; f <= 16; f++) begin
         if (!timed_out) begin
            waited = 0;
            seen   = 1'b0;
            while (!seen && waited < 40) begin
               step(1'b1, 1'b0, 1'b1);
               waited++;
               if (mat_w) seen = 1'b1;
            end
            check("matrix_start within bound", seen, 1'b1);
            if (!seen) timed_out = 1'b1;
            else begin
               step(1'b1, 1'b1, 1'b1);
               step(1'b1, 1'b1, 1'b1);
               check($sformatf("frame_done f%0d", f), done_w, 1'b1);
               if (f == 15) check("narrow frame_count max", frm_w, 4'hF);
               if (f == 16) check("narrow frame_count wrap", frm_w, 4'h0);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
